// File: rtl/seq_multiplier64_pkg.sv
// Shared definitions for the iterative unsigned multiplier and its wrappers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_multiplier64_pkg;

    // Default operand width; the adder slices in groups of 4 bits, so any
    // override must stay a multiple of 4.
    localparam int DEFAULT_WIDTH = 64;

    // Control state encoding, also reused by the signed-multiply wrapper.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier64_full_adder.sv
// Ripple-carry adder built from 4-bit slices, carry chained slice to slice.
// Latency: purely combinational.
// Backpressure: none.
module FullAdder64 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             CarryIn,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut
);

    localparam int SLICES = WIDTH / 4;

    logic       carry;
    logic [4:0] slice_sum;

    // Walk the slices LSB first, each slice consuming the previous carry.
    always_comb begin
        carry     = CarryIn;
        slice_sum = '0;
        Sum       = '0;
        for (int s = 0; s < SLICES; s++) begin
            slice_sum       = {1'b0, X[4*s +: 4]} + {1'b0, Y[4*s +: 4]} + {4'b0000, carry};
            Sum[4*s +: 4]   = slice_sum[3:0];
            carry           = slice_sum[4];
        end
        CarryOut = carry;
    end

endmodule

// File: rtl/seq_multiplier64.sv
// Shift-and-add unsigned multiplier: one partial product per cycle, 2*WIDTH-bit result.
// Latency: WIDTH+1 edges from operand acceptance to OutValid; fixed, no early exit.
// Backpressure: InReady only in IDLE; Product held stable in DONE until OutReady.
module seq_multiplier64
    import seq_multiplier64_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               InValid,
    output logic               InReady,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [2*WIDTH-1:0] Product,
    output logic               Busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] add_y;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    // When the current multiplier bit is 0 the adder sees Y = 0, so its
    // result is simply {0, hi}; one shared path covers both cases.
    assign add_y = lo[0] ? mcand : '0;

    FullAdder64 #(
        .WIDTH    (WIDTH)
    ) u_adder (
        .X        (hi),
        .Y        (add_y),
        .CarryIn  (1'b0),
        .Sum      (add_sum),
        .CarryOut (add_cout)
    );

    // State register; reset aborts any in-flight product immediately.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, count WIDTH steps, hand off in DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (InValid && InReady) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, then shift {carry, sum, lo} right
    // once per RUN cycle. The carry lands in hi's MSB, so nothing is lost.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        mcand <= A;
                        hi    <= '0;
                        lo    <= B;
                        count <= '0;
                    end
                end
                RUN: begin
                    {hi, lo} <= {add_cout, add_sum, lo[WIDTH-1:1]};
                    count    <= count + CW'(1);
                end
                default: begin
                    // DONE holds the finished product until it is taken.
                end
            endcase
        end
    end

    assign InReady  = (state == IDLE);
    assign Busy     = (state == RUN);
    assign OutValid = (state == DONE);
    assign Product  = (state == DONE) ? {hi, lo} : '0;

endmodule

// File: tb/tb_seq_multiplier64.sv
// Directed and randomized checks of seq_multiplier64 against a plain multiply.
// Latency: checks the fixed 65-edge accept-to-OutValid latency.
// Backpressure: exercises OutReady stalls and InValid while busy.
module tb_seq_multiplier64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] product;
    logic         busy;

    int tests = 0;
    int fails = 0;

    seq_multiplier64 #(
        .WIDTH    (64)
    ) dut (
        .Clock    (clk),
        .Reset_n  (rst_n),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .A        (a),
        .B        (b),
        .OutValid (out_valid),
        .OutReady (out_ready),
        .Product  (product),
        .Busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y);
        return 128'(x) * 128'(y);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer operands at a negedge; they are accepted at the following posedge.
    task automatic start_op(input logic [63:0] x, input logic [63:0] y);
        @(negedge clk);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        chk("ready_before_accept", 128'(in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ready_drops_after_accept", 128'(in_ready), 128'(0));
        chk("busy_after_accept", 128'(busy), 128'(1));
    endtask

    // Counts edges with the acceptance edge as edge 1; bounded.
    task automatic wait_valid(output int edges);
        edges = 1;
        while (!out_valid && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("ready_after_handoff", 128'(in_ready), 128'(1));
        chk("valid_after_handoff", 128'(out_valid), 128'(0));
        chk("product_zero_idle", product, 128'(0));
    endtask

    task automatic run_directed(input string tag, input logic [63:0] x, input logic [63:0] y);
        int edges;
        start_op(x, y);
        wait_valid(edges);
        chk({tag, "_latency"}, 128'(edges), 128'(65));
        chk({tag, "_product"}, product, ref_mul(x, y));
        handoff();
    endtask

    function automatic logic [63:0] rand_operand();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
        if (sel == 1) return 64'h0;
        if (sel == 2) return 64'(1) << $urandom_range(0, 63);
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        logic [127:0] exp_p;
        logic [127:0] expq[$];
        int           edges;
        int           sent;
        int           got;
        int           cycles;
        logic         holding;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        // Reset values
        #3;
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_product", product, 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic product, OutReady already high when OutValid rises
        start_op(64'd3, 64'd5);
        out_ready = 1'b1;
        wait_valid(edges);
        chk("small_latency", 128'(edges), 128'(65));
        chk("small_product", product, 128'd15);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("small_ready_back", 128'(in_ready), 128'(1));
        chk("small_valid_low", 128'(out_valid), 128'(0));

        run_directed("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("all_ones_const", ref_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF),
            128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        run_directed("msb_times_two", 64'h8000_0000_0000_0000, 64'd2);
        run_directed("msb_times_zero", 64'h8000_0000_0000_0000, 64'd0);

        // Stall: hold OutReady low for 10 cycles, poke InValid meanwhile
        start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        exp_p = ref_mul(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        wait_valid(edges);
        chk("stall_latency", 128'(edges), 128'(65));
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a        = 64'd11;
                b        = 64'd13;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("stall_valid", 128'(out_valid), 128'(1));
            chk("stall_product", product, exp_p);
            chk("stall_in_ready", 128'(in_ready), 128'(0));
            @(negedge clk);
        end
        in_valid = 1'b0;
        handoff();
        run_directed("after_stall", 64'd9, 64'd10);

        // Asynchronous reset in the middle of RUN
        start_op(64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0003);
        repeat (29) @(negedge clk);
        chk("pre_reset_busy", 128'(busy), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_in_ready", 128'(in_ready), 128'(1));
        chk("async_busy", 128'(busy), 128'(0));
        chk("async_out_valid", 128'(out_valid), 128'(0));
        chk("async_product", product, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_directed("post_reset", 64'd7, 64'd6);

        // Randomized traffic with random consumer gaps
        sent    = 0;
        got     = 0;
        cycles  = 0;
        holding = 1'b0;
        while (got < 100 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (!holding && sent < 100 && $urandom_range(0, 2) != 0) begin
                a        = rand_operand();
                b        = rand_operand();
                in_valid = 1'b1;
                holding  = 1'b1;
            end else if (!holding) begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                expq.push_back(ref_mul(a, b));
                sent++;
                holding = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk("rand_output_expected", 128'(expq.size()), 128'(1));
                if (expq.size() > 0) begin
                    chk("rand_product", product, expq.pop_front());
                end
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rand_outputs_seen", 128'(got), 128'(100));
        chk("rand_inputs_sent", 128'(sent), 128'(100));
        chk("rand_queue_drained", 128'(expq.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
